// File: rtl/anubis_link_ctrl.sv
// anubis_link_ctrl: four-phase serial link front end that frames one Anubis core operation per request
module anubis_link_ctrl #(
  parameter int DATA_W = 128,
  parameter int KEY_W = 128,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic              clk,
  input  logic              reset_b,
  input  logic              rxd,
  input  logic              rx_sync,
  output logic              rx_ack,
  output logic              txd,
  output logic              tx_sync,
  input  logic              tx_ack,
  output logic              core_start,
  output logic              core_encrypt,
  output logic              core_key_new,
  output logic [DATA_W-1:0] core_data,
  output logic [KEY_W-1:0]  core_key,
  input  logic              core_done,
  input  logic [DATA_W-1:0] core_result,
  output logic              busy,
  output logic              key_valid,
  output logic              frame_err
);
  localparam int MAXW = DATA_W > KEY_W ? DATA_W : KEY_W;
  localparam int CW = $clog2(MAXW + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  typedef enum logic [2:0] {IDLE, RX_HDR, RX_DATA, RX_KEY, CORE_REQ, CORE_WAIT, TX_BIT} state_t;
  state_t state, nxt;
  logic [SYNC_STAGES-1:0] rxd_q, sync_q, ack_q;
  logic [7:0] hdr;
  logic [DATA_W-1:0] data_sr, tx_sr;
  logic [KEY_W-1:0] key_sr;
  logic [CW-1:0] cnt;
  logic [TW-1:0] tmo;
  logic [1:0] tx_ph;
  logic s_rxd, s_sync, s_ack, armed, rx_st, take, done_bit, last, hdr_bad, hdr_err;
  logic tx_done, timing, progress, abort, err;
  assign s_rxd = rxd_q[SYNC_STAGES-1];
  assign s_sync = sync_q[SYNC_STAGES-1];
  assign s_ack = ack_q[SYNC_STAGES-1];
  assign rx_st = state == RX_HDR || state == RX_DATA || state == RX_KEY;
  assign take = rx_st && !rx_ack && s_sync;
  assign done_bit = rx_st && rx_ack && !s_sync;
  assign last = cnt == CW'(state == RX_HDR ? 7 : state == RX_KEY ? KEY_W - 1 : DATA_W - 1);
  assign hdr_bad = |hdr[5:0] || (hdr[6] && !key_valid);
  assign hdr_err = state == RX_HDR && done_bit && last && hdr_bad;
  assign tx_done = state == TX_BIT && tx_ph == 2'd2 && !s_ack;
  assign timing = rx_st || state == TX_BIT;
  assign progress = take || done_bit || (state == TX_BIT && (tx_ph == 2'd0 || (tx_ph == 2'd1 && s_ack) || tx_done));
  assign abort = timing && tmo == TW'(TIMEOUT_CYC);
  assign err = abort || hdr_err;
  assign core_start = state == CORE_REQ;
  assign core_key_new = core_start && !hdr[6];
  assign busy = state != IDLE;
  assign tx_sync = state == TX_BIT && tx_ph == 2'd1;
  assign txd = state == TX_BIT && tx_sr[DATA_W-1];
  // state register
  always_ff @(posedge clk or negedge reset_b)
    if (!reset_b) state <= IDLE;
    else state <= nxt;
  // next state: a timeout beats any handshake progress in the same cycle
  always_comb begin
    nxt = state;
    case (state)
      IDLE:      nxt = (s_sync && armed) ? RX_HDR : IDLE;
      RX_HDR:    nxt = (done_bit && last) ? (hdr_bad ? IDLE : RX_DATA) : RX_HDR;
      RX_DATA:   nxt = (done_bit && last) ? (hdr[6] ? CORE_REQ : RX_KEY) : RX_DATA;
      RX_KEY:    nxt = (done_bit && last) ? CORE_REQ : RX_KEY;
      CORE_REQ:  nxt = CORE_WAIT;
      CORE_WAIT: nxt = core_done ? TX_BIT : CORE_WAIT;
      TX_BIT:    nxt = (tx_done && last) ? IDLE : TX_BIT;
      default:   nxt = IDLE;
    endcase
    if (abort) nxt = IDLE;
  end
  // synchronisers, handshake, shift registers, timeout and core-side registers
  always_ff @(posedge clk or negedge reset_b)
    if (!reset_b) begin
      rxd_q <= '0;
      sync_q <= '0;
      ack_q <= '0;
      armed <= 1'b1;
      rx_ack <= 1'b0;
      frame_err <= 1'b0;
      hdr <= '0;
      data_sr <= '0;
      key_sr <= '0;
      tx_sr <= '0;
      tx_ph <= '0;
      cnt <= '0;
      tmo <= '0;
      core_data <= '0;
      core_key <= '0;
      core_encrypt <= 1'b0;
      key_valid <= 1'b0;
    end else begin
      rxd_q <= {rxd_q[SYNC_STAGES-2:0], rxd};
      sync_q <= {sync_q[SYNC_STAGES-2:0], rx_sync};
      ack_q <= {ack_q[SYNC_STAGES-2:0], tx_ack};
      armed <= !s_sync || (armed && !err);
      rx_ack <= take || (rx_ack && !done_bit && !abort);
      frame_err <= err;
      tmo <= (!timing || progress || nxt != state) ? '0 : tmo + 1'b1;
      cnt <= nxt != state ? '0 : (done_bit || tx_done) ? cnt + 1'b1 : cnt;
      if (take && state == RX_HDR) hdr <= {hdr[6:0], s_rxd};
      if (take && state == RX_DATA) data_sr <= {data_sr[DATA_W-2:0], s_rxd};
      if (take && state == RX_KEY) key_sr <= {key_sr[KEY_W-2:0], s_rxd};
      if (nxt == CORE_REQ && state != CORE_REQ) begin
        core_data <= data_sr;
        core_encrypt <= hdr[7];
        if (!hdr[6]) begin
          core_key <= key_sr;
          key_valid <= 1'b1;
        end
      end
      if (state == CORE_WAIT && core_done) begin
        tx_sr <= core_result;
        tx_ph <= 2'd0;
      end else if (state == TX_BIT) begin
        tx_ph <= tx_ph == 2'd0 ? 2'd1 : (tx_ph == 2'd1 && s_ack) ? 2'd2 : tx_done ? 2'd0 : tx_ph;
        if (tx_done) tx_sr <= {tx_sr[DATA_W-2:0], 1'b0};
      end
    end
endmodule
